lfsr_checker: RTL

- Downstream consumer of the 4-bit serial LFSR generator (taps s[2]^s[3], polynomial x^4+x^3+1, period 15).
- Receives the generator's serial bit stream and self-synchronises a local predictor from the received bits.
- Declares lock, then flags and counts bit errors, and drops lock on excessive error density.
- Sits between the generator output q and the status/display logic.

---
 rtl/lfsr_checker_pkg.sv | 15 +
 rtl/lfsr_checker_predictor.sv | 33 +++
 rtl/lfsr_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the serial LFSR stream checker: state encoding and
// default predictor geometry matching the 4-bit x^4+x^3+1 generator.
package lfsr_checker_pkg;

    localparam int DEF_LEN   = 4;
    localparam int DEF_TAP_A = 2;
    localparam int DEF_TAP_B = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } sync_state_t;

endpackage

// File: rtl/lfsr_checker_predictor.sv
// Local copy of the generator state rebuilt from received bits; predicts the
// next bit and flags the all-zero history that a valid stream never produces.
module lfsr_predictor #(
    parameter int LEN   = 4,
    parameter int TAP_A = 2,
    parameter int TAP_B = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic din_valid,
    output logic mismatch,
    output logic hist_zero
);

    logic [LEN-1:0] hist_q;
    logic [LEN-1:0] hist_next;
    logic           expected;

    // Index 0 is the most recently received bit.
    assign hist_next = {hist_q[LEN-2:0], din};
    assign expected  = hist_q[TAP_A] ^ hist_q[TAP_B];
    assign mismatch  = din ^ expected;
    assign hist_zero = (hist_next == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist_q <= '0;
        else if (din_valid)
            hist_q <= hist_next;
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the serial LFSR stream: hunts, syncs, locks,
// then counts bit errors and drops lock on excessive error density.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int LEN      = DEF_LEN,
    parameter int TAP_A    = DEF_TAP_A,
    parameter int TAP_B    = DEF_TAP_B,
    parameter int LOCK_CNT = 8,
    parameter int ERR_WIN  = 16,
    parameter int ERR_LIM  = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic [1:0]       sync_state
);

    localparam int FILL_W = $clog2(LEN + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(ERR_WIN + 1);
    localparam int WERR_W = $clog2(ERR_LIM + 1);

    logic mismatch;
    logic hist_zero;

    sync_state_t       state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WERR_W-1:0] werr_q, werr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [CNT_W-1:0]  bit_count_q, bit_count_d;

    lfsr_predictor #(
        .LEN   (LEN),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_pred (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .mismatch  (mismatch),
        .hist_zero (hist_zero)
    );

    assign fill_inc = (fill_q == FILL_W'(LEN)) ? fill_q : fill_q + FILL_W'(1);

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        good_d      = good_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;

        case (state_q)
            HUNT: begin
                if (din_valid) begin
                    fill_d = fill_inc;
                    if (fill_inc == FILL_W'(LEN) && !hist_zero) begin
                        state_d = SYNC;
                        good_d  = '0;
                    end
                end
            end
            SYNC: begin
                if (din_valid) begin
                    if (hist_zero) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (!mismatch) begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    bit_count_d = (bit_count_q == '1) ? bit_count_q : bit_count_q + CNT_W'(1);
                    win_d       = win_q + WIN_W'(1);
                    if (mismatch) begin
                        err_d       = 1'b1;
                        err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CNT_W'(1);
                        werr_d      = werr_q + WERR_W'(1);
                    end
                    // Losing lock wins over closing the window on the same bit.
                    if (hist_zero || (mismatch && werr_q == WERR_W'(ERR_LIM - 1))) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (win_q == WIN_W'(ERR_WIN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                fill_d  = '0;
            end
        endcase

        if (clear) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            fill_q      <= '0;
            good_q      <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign locked     = (state_q == LOCKED);
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign bit_count  = bit_count_q;
    assign sync_state = state_q;

endmodule
